// File: rtl/debug_unit_gen.sv
// Debug unit for a pipelined CPU. It takes commands from a UART receiver and
// loads instruction memory, then runs or single-steps the pipeline. After a
// halt or a step it dumps PC, cycle count, registers and data memory over the
// UART transmitter, one byte at a time.
module debug_unit_gen #(
    parameter int NB_DATA  = 32,
    parameter int NB_IADDR = 7,
    parameter int N_REGS   = 32,
    parameter int NB_MADDR = 7,
    localparam int NB_RADDR = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_byte,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    input  logic                i_halt,
    input  logic [NB_IADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0]  i_reg_data,
    input  logic [NB_DATA-1:0]  i_mem_data,
    output logic [7:0]          o_tx_byte,
    output logic                o_tx_start,
    output logic                o_enable_pipe,
    output logic                o_imem_we,
    output logic [NB_IADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]  o_imem_data,
    output logic                o_load_sel,
    output logic [NB_RADDR-1:0] o_reg_addr,
    output logic [NB_MADDR-1:0] o_mem_addr,
    output logic [3:0]          o_state
);

    localparam int NB_WORD    = (NB_DATA > 32) ? NB_DATA : 32;
    localparam int NB_CNT     = NB_IADDR + 1;
    localparam int NB_BCNT    = $clog2(NB_WORD / 8) + 1;
    localparam int IMEM_WORDS = 1 << NB_IADDR;
    localparam int DATA_BYTES = NB_DATA / 8;

    localparam logic [NB_BCNT-1:0]  DATA_BYTES_C = NB_BCNT'(DATA_BYTES);
    localparam logic [NB_BCNT-1:0]  WORD32_BYTES = NB_BCNT'(4);
    localparam logic [NB_RADDR-1:0] LAST_REG     = NB_RADDR'(N_REGS - 1);

    localparam logic [7:0] CMD_LOAD      = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'h10;
    localparam logic [7:0] CMD_STEP      = 8'h20;
    localparam logic [7:0] CMD_STEP_GO   = 8'h30;
    localparam logic [7:0] CMD_STEP_EXIT = 8'h2F;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LD_CNT   = 4'd1,
        S_LD_BYTE  = 4'd2,
        S_LD_WR    = 4'd3,
        S_RUN      = 4'd4,
        S_STEP     = 4'd5,
        S_SEND_PC  = 4'd6,
        S_SEND_CYC = 4'd7,
        S_SEND_REG = 4'd8,
        S_SEND_MEM = 4'd9
    } state_t;

    // Each dumped word goes through: address settle, capture, then per byte
    // a start request followed by a wait for the transmitter.
    typedef enum logic [1:0] {
        PH_ADDR  = 2'd0,
        PH_LOAD  = 2'd1,
        PH_START = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [NB_WORD-1:0]  shift_q, shift_d;
    logic [NB_BCNT-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NB_CNT-1:0]   word_idx_q, word_idx_d;
    logic [NB_CNT-1:0]   word_cnt_q, word_cnt_d;
    logic [NB_RADDR-1:0] reg_addr_q, reg_addr_d;
    logic [NB_MADDR-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                tx_start_q, tx_start_d;
    logic                step_mode_q, step_mode_d;
    logic                step_go_q, step_go_d;
    logic                halt_seen_q, halt_seen_d;
    logic                enable_pipe;
    logic [31:0]         cyc_inc;

    assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

    // Command decoding, load sequencing, run/step control and dump sequencing.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cyc_d       = cyc_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        word_cnt_d  = word_cnt_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        tx_byte_d   = tx_byte_q;
        tx_start_d  = 1'b0;
        step_mode_d = step_mode_q;
        step_go_d   = step_go_q;
        halt_seen_d = halt_seen_q;
        enable_pipe = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_byte)
                        CMD_LOAD: state_d = S_LD_CNT;
                        CMD_RUN: begin
                            state_d     = S_RUN;
                            cyc_d       = '0;
                            step_mode_d = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d     = S_STEP;
                            cyc_d       = '0;
                            step_mode_d = 1'b1;
                            step_go_d   = 1'b0;
                            halt_seen_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LD_CNT: begin
                if (i_rx_done) begin
                    if (i_rx_byte == 8'h00) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_LD_BYTE;
                        word_idx_d = '0;
                        byte_cnt_d = DATA_BYTES_C;
                        if (int'(i_rx_byte) > IMEM_WORDS) begin
                            word_cnt_d = NB_CNT'(IMEM_WORDS);
                        end else begin
                            word_cnt_d = NB_CNT'(i_rx_byte);
                        end
                    end
                end
            end
            S_LD_BYTE: begin
                if (i_rx_done) begin
                    shift_d = {shift_q[NB_WORD-9:0], i_rx_byte};
                    if (byte_cnt_q == NB_BCNT'(1)) begin
                        state_d = S_LD_WR;
                    end else begin
                        byte_cnt_d = byte_cnt_q - NB_BCNT'(1);
                    end
                end
            end
            S_LD_WR: begin
                word_idx_d = word_idx_q + NB_CNT'(1);
                byte_cnt_d = DATA_BYTES_C;
                if (word_idx_q + NB_CNT'(1) == word_cnt_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LD_BYTE;
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_SEND_PC;
                    phase_d = PH_ADDR;
                end else begin
                    enable_pipe = 1'b1;
                    cyc_d       = cyc_inc;
                end
            end
            S_STEP: begin
                if (step_go_q) begin
                    enable_pipe = 1'b1;
                    cyc_d       = cyc_inc;
                    halt_seen_d = i_halt;
                    step_go_d   = 1'b0;
                    state_d     = S_SEND_PC;
                    phase_d     = PH_ADDR;
                end else if (i_rx_done) begin
                    if (i_rx_byte == CMD_STEP_GO) begin
                        step_go_d = 1'b1;
                    end else if (i_rx_byte == CMD_STEP_EXIT) begin
                        state_d     = S_IDLE;
                        step_mode_d = 1'b0;
                    end
                end
            end
            S_SEND_PC, S_SEND_CYC, S_SEND_REG, S_SEND_MEM: begin
                case (phase_q)
                    PH_ADDR: phase_d = PH_LOAD;
                    PH_LOAD: begin
                        phase_d = PH_START;
                        case (state_q)
                            S_SEND_PC: begin
                                shift_d    = NB_WORD'(i_pc) << (NB_WORD - 32);
                                byte_cnt_d = WORD32_BYTES;
                            end
                            S_SEND_CYC: begin
                                shift_d    = NB_WORD'(cyc_q) << (NB_WORD - 32);
                                byte_cnt_d = WORD32_BYTES;
                            end
                            S_SEND_REG: begin
                                shift_d    = NB_WORD'(i_reg_data) << (NB_WORD - NB_DATA);
                                byte_cnt_d = DATA_BYTES_C;
                            end
                            default: begin
                                shift_d    = NB_WORD'(i_mem_data) << (NB_WORD - NB_DATA);
                                byte_cnt_d = DATA_BYTES_C;
                            end
                        endcase
                    end
                    PH_START: begin
                        tx_byte_d  = shift_q[NB_WORD-1 -: 8];
                        tx_start_d = 1'b1;
                        phase_d    = PH_WAIT;
                    end
                    default: begin
                        if (i_tx_done) begin
                            if (byte_cnt_q > NB_BCNT'(1)) begin
                                shift_d    = {shift_q[NB_WORD-9:0], 8'h00};
                                byte_cnt_d = byte_cnt_q - NB_BCNT'(1);
                                phase_d    = PH_START;
                            end else begin
                                phase_d = PH_ADDR;
                                case (state_q)
                                    S_SEND_PC: state_d = S_SEND_CYC;
                                    S_SEND_CYC: begin
                                        state_d    = S_SEND_REG;
                                        reg_addr_d = '0;
                                    end
                                    S_SEND_REG: begin
                                        if (reg_addr_q == LAST_REG) begin
                                            state_d    = S_SEND_MEM;
                                            mem_addr_d = '0;
                                        end else begin
                                            reg_addr_d = reg_addr_q + NB_RADDR'(1);
                                        end
                                    end
                                    default: begin
                                        if (mem_addr_q == '1) begin
                                            reg_addr_d = '0;
                                            mem_addr_d = '0;
                                            if (step_mode_q && !halt_seen_q) begin
                                                state_d = S_STEP;
                                            end else begin
                                                state_d     = S_IDLE;
                                                step_mode_d = 1'b0;
                                            end
                                        end else begin
                                            mem_addr_d = mem_addr_q + NB_MADDR'(1);
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any load or dump in progress.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ADDR;
            cyc_q       <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            word_cnt_q  <= '0;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            step_mode_q <= 1'b0;
            step_go_q   <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cyc_q       <= cyc_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            word_cnt_q  <= word_cnt_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            tx_byte_q   <= tx_byte_d;
            tx_start_q  <= tx_start_d;
            step_mode_q <= step_mode_d;
            step_go_q   <= step_go_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    assign o_tx_byte     = tx_byte_q;
    assign o_tx_start    = tx_start_q;
    assign o_enable_pipe = enable_pipe;
    assign o_imem_we     = (state_q == S_LD_WR);
    assign o_imem_addr   = word_idx_q[NB_IADDR-1:0];
    assign o_imem_data   = shift_q[NB_DATA-1:0];
    assign o_load_sel    = (state_q == S_LD_CNT) || (state_q == S_LD_BYTE) || (state_q == S_LD_WR);
    assign o_reg_addr    = reg_addr_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_debug_unit_gen.sv
// Directed testbench for debug_unit_gen: load, run, step, dump, stall and reset.
module tb_debug_unit_gen;

    localparam int DUMP_BYTES = 4 + 4 + 32 * 4 + 128 * 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_byte;
    logic        i_rx_done;
    logic        i_tx_done;
    logic        i_halt;
    logic [6:0]  i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [7:0]  o_tx_byte;
    logic        o_tx_start;
    logic        o_enable_pipe;
    logic        o_imem_we;
    logic [6:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_load_sel;
    logic [4:0]  o_reg_addr;
    logic [6:0]  o_mem_addr;
    logic [3:0]  o_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  dump_q[$];
    bit          dump_ok;
    logic [6:0]  we_addr_q[$];
    logic [31:0] we_data_q[$];

    always #5 clk = ~clk;

    debug_unit_gen dut (
        .i_clock(clk), .i_reset(i_reset), .i_rx_byte(i_rx_byte), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .i_halt(i_halt), .i_pc(i_pc), .i_reg_data(i_reg_data),
        .i_mem_data(i_mem_data), .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start),
        .o_enable_pipe(o_enable_pipe), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
        .o_imem_data(o_imem_data), .o_load_sel(o_load_sel), .o_reg_addr(o_reg_addr),
        .o_mem_addr(o_mem_addr), .o_state(o_state)
    );

    function automatic logic [31:0] reg_word(input logic [4:0] a);
        return {8'hA0, 3'b000, a, 8'h3C, 3'b000, a};
    endfunction

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return {8'hC0, 1'b0, a, 8'hE1, 1'b0, ~a};
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pc, input logic [31:0] cyc);
        logic [31:0] w;
        int sh;
        sh = 3 - (k % 4);
        if (k < 4) w = pc;
        else if (k < 8) w = cyc;
        else if (k < 136) w = reg_word(5'((k - 8) / 4));
        else w = mem_word(7'((k - 136) / 4));
        return w[8*sh +: 8];
    endfunction

    function automatic int dump_mismatches(input logic [31:0] pc, input logic [31:0] cyc);
        int n;
        n = 0;
        for (int k = 0; k < dump_q.size(); k++) begin
            if (dump_q[k] !== exp_byte(k, pc, cyc)) n++;
        end
        return n;
    endfunction

    // Register bank and data memory modelled as synchronous-read RAMs.
    always @(posedge clk) begin
        i_reg_data <= reg_word(o_reg_addr);
        i_mem_data <= mem_word(o_mem_addr);
    end

    // Record every instruction-memory write strobe.
    always @(negedge clk) begin
        if (o_imem_we === 1'b1) begin
            we_addr_q.push_back(o_imem_addr);
            we_data_q.push_back(o_imem_data);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_rx_byte = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_start(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b0;
        b = 8'h00;
        n = 0;
        while (!ok && n < 200) begin
            tick();
            n++;
            if (o_tx_start === 1'b1) begin
                ok = 1'b1;
                b = o_tx_byte;
            end
        end
    endtask

    task automatic ack();
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic collect_dump(input int nbytes);
        logic [7:0] b;
        bit ok;
        dump_q.delete();
        dump_ok = 1'b1;
        for (int i = 0; i < nbytes && dump_ok; i++) begin
            wait_start(b, ok);
            if (!ok) dump_ok = 1'b0;
            else begin
                dump_q.push_back(b);
                ack();
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_rx_byte = 8'h00; i_rx_done = 1'b0; i_tx_done = 1'b0;
        i_halt = 1'b0; i_pc = 7'd0;
        repeat (3) tick();
        checks++;
        if (o_state !== 4'd0 || o_tx_start !== 1'b0 || o_enable_pipe !== 1'b0 || o_load_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl state=%0d start=%b en=%b sel=%b want 0/0/0/0", o_state, o_tx_start, o_enable_pipe, o_load_sel);
        end
        checks++;
        if (o_tx_byte !== 8'h00 || o_imem_we !== 1'b0 || o_imem_addr !== 7'd0 || o_reg_addr !== 5'd0 || o_mem_addr !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_data byte=%h we=%b ia=%0d ra=%0d ma=%0d want 0", o_tx_byte, o_imem_we, o_imem_addr, o_reg_addr, o_mem_addr);
        end
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_state got %0d want 0", o_state);
        end
    endtask

    task automatic test_load();
        we_addr_q.delete(); we_data_q.delete();
        send_byte(8'h01, 1);
        checks++;
        if (o_state !== 4'd1 || o_load_sel !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_cnt_state got %0d sel %b want 1 sel 1", o_state, o_load_sel);
        end
        send_byte(8'h02, 1);
        for (int i = 2; i <= 9; i++) send_byte(8'(i), 1);
        checks++;
        if (we_addr_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL load_we_count got %0d want 2", we_addr_q.size());
        end else begin
            checks++;
            if (we_addr_q[0] !== 7'd0 || we_data_q[0] !== 32'h0203_0405) begin
                errors++;
                $display("[TB] FAIL load_word0 got %0d/%h want 0/02030405", we_addr_q[0], we_data_q[0]);
            end
            checks++;
            if (we_addr_q[1] !== 7'd1 || we_data_q[1] !== 32'h0607_0809) begin
                errors++;
                $display("[TB] FAIL load_word1 got %0d/%h want 1/06070809", we_addr_q[1], we_data_q[1]);
            end
        end
        checks++;
        if (o_state !== 4'd0 || o_load_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_end_state got %0d sel %b want 0 sel 0", o_state, o_load_sel);
        end
    endtask

    task automatic test_load_zero_and_ignore();
        we_addr_q.delete(); we_data_q.delete();
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL zero_count_state got %0d want 0", o_state);
        end
        send_byte(8'h55, 1);
        i_halt = 1'b1;
        tick(); tick();
        checks++;
        if (o_state !== 4'd0 || o_enable_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignore state %0d en %b want 0 en 0", o_state, o_enable_pipe);
        end
        i_halt = 1'b0;
        checks++;
        if (we_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_count_we got %0d want 0", we_addr_q.size());
        end
    endtask

    task automatic test_load_clamp();
        logic [7:0] idx;
        we_addr_q.delete(); we_data_q.delete();
        send_byte(8'h01, 1);
        send_byte(8'd200, 1);
        for (int i = 0; i < 128; i++) begin
            idx = 8'(i);
            send_byte(idx, 1);
            send_byte(8'h11, 1);
            send_byte(8'h22, 1);
            send_byte(~idx, 1);
        end
        checks++;
        if (we_addr_q.size() != 128) begin
            errors++;
            $display("[TB] FAIL clamp_we_count got %0d want 128", we_addr_q.size());
        end else begin
            checks++;
            if (we_addr_q[127] !== 7'd127 || we_data_q[127] !== 32'h7F11_2280) begin
                errors++;
                $display("[TB] FAIL clamp_last_word got %0d/%h want 127/7f112280", we_addr_q[127], we_data_q[127]);
            end
        end
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL clamp_end_state got %0d want 0", o_state);
        end
    endtask

    task automatic test_run_dump();
        int mm;
        i_pc = 7'd3;
        send_byte(8'h10, 0);
        checks++;
        if (o_state !== 4'd4 || o_enable_pipe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_enter state %0d en %b want 4 en 1", o_state, o_enable_pipe);
        end
        repeat (4) tick();
        i_halt = 1'b1;
        i_rx_byte = 8'h2F;
        i_rx_done = 1'b1;
        #1;
        checks++;
        if (o_enable_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_same_cycle en got %b want 0", o_enable_pipe);
        end
        tick();
        i_halt = 1'b0;
        i_rx_done = 1'b0;
        checks++;
        if (o_state !== 4'd6) begin
            errors++;
            $display("[TB] FAIL halt_priority state got %0d want 6", o_state);
        end
        collect_dump(DUMP_BYTES);
        mm = dump_mismatches(32'd3, 32'd4);
        checks++;
        if (!dump_ok || mm != 0) begin
            errors++;
            $display("[TB] FAIL run_dump got %0d bytes %0d wrong want %0d bytes 0 wrong", dump_q.size(), mm, DUMP_BYTES);
        end
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL run_end_state got %0d want 0", o_state);
        end
    endtask

    task automatic test_step();
        int mm;
        i_pc = 7'h11;
        send_byte(8'h20, 0);
        send_byte(8'h55, 0);
        checks++;
        if (o_state !== 4'd5 || o_enable_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_enter state %0d en %b want 5 en 0", o_state, o_enable_pipe);
        end
        for (int s = 1; s <= 2; s++) begin
            send_byte(8'h30, 0);
            checks++;
            if (o_enable_pipe !== 1'b1) begin
                errors++;
                $display("[TB] FAIL step_pulse_%0d en got %b want 1", s, o_enable_pipe);
            end
            tick();
            checks++;
            if (o_enable_pipe !== 1'b0 || o_state !== 4'd6) begin
                errors++;
                $display("[TB] FAIL step_pulse_end_%0d en %b state %0d want 0 state 6", s, o_enable_pipe, o_state);
            end
            collect_dump(DUMP_BYTES);
            mm = dump_mismatches(32'h11, 32'(s));
            checks++;
            if (!dump_ok || mm != 0) begin
                errors++;
                $display("[TB] FAIL step_dump_%0d got %0d bytes %0d wrong want %0d bytes 0 wrong", s, dump_q.size(), mm, DUMP_BYTES);
            end
            checks++;
            if (o_state !== 4'd5) begin
                errors++;
                $display("[TB] FAIL step_return_%0d state got %0d want 5", s, o_state);
            end
        end
        send_byte(8'h2F, 0);
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL step_exit state got %0d want 0", o_state);
        end
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        collect_dump(DUMP_BYTES);
        mm = dump_mismatches(32'h11, 32'd1);
        checks++;
        if (!dump_ok || mm != 0) begin
            errors++;
            $display("[TB] FAIL step_halt_dump got %0d bytes %0d wrong want %0d bytes 0 wrong", dump_q.size(), mm, DUMP_BYTES);
        end
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL step_halt_end state got %0d want 0", o_state);
        end
    endtask

    task automatic test_stall_and_reset();
        logic [7:0] b;
        bit ok;
        int bad;
        int mm;
        i_pc = 7'd5;
        send_byte(8'h10, 0);
        repeat (2) tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        wait_start(b, ok);
        checks++;
        if (!ok || b !== 8'h00) begin
            errors++;
            $display("[TB] FAIL stall_first_byte ok %b got %h want 00", ok, b);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_tx_start !== 1'b0 || o_tx_byte !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        ack();
        collect_dump(7);
        mm = 0;
        for (int k = 0; k < dump_q.size(); k++) begin
            if (dump_q[k] !== exp_byte(k + 1, 32'd5, 32'd2)) mm++;
        end
        checks++;
        if (!dump_ok || mm != 0) begin
            errors++;
            $display("[TB] FAIL stall_rest got %0d bytes %0d wrong want 7 bytes 0 wrong", dump_q.size(), mm);
        end
        collect_dump(6);
        checks++;
        if (o_state !== 4'd8) begin
            errors++;
            $display("[TB] FAIL mid_reg_state got %0d want 8", o_state);
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_state !== 4'd0 || o_tx_byte !== 8'h00 || o_tx_start !== 1'b0 || o_reg_addr !== 5'd0 || o_enable_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset state %0d byte %h start %b ra %0d en %b want all 0", o_state, o_tx_byte, o_tx_start, o_reg_addr, o_enable_pipe);
        end
        tick(); tick();
        i_reset = 1'b1;
        tick();
        i_pc = 7'd9;
        send_byte(8'h10, 0);
        repeat (3) tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        collect_dump(8);
        mm = dump_mismatches(32'd9, 32'd3);
        checks++;
        if (!dump_ok || mm != 0) begin
            errors++;
            $display("[TB] FAIL rerun_count got %0d bytes %0d wrong want 8 bytes 0 wrong", dump_q.size(), mm);
        end
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL abort_state got %0d want 0", o_state);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_zero_and_ignore();
        test_load_clamp();
        test_run_dump();
        test_step();
        test_stall_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_unit_gen.md
DEBUG_UNIT_GEN -- requirements
Module: debug_unit_gen

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NB_DATA, 32: instruction, register and memory word width; multiple of 8.
- NB_IADDR, 7: instruction-memory address width.
- N_REGS, 32: number of registers dumped.
- NB_MADDR, 7: data-memory address width; 2^NB_MADDR words dumped.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_rx_byte  in  8  byte from external UART receiver.
- i_rx_done  in  1  one-cycle strobe; i_rx_byte valid.
- i_tx_done  in  1  one-cycle strobe; UART finished previous byte.
- i_halt  in  1  pipeline reached halt instruction.
- i_pc  in  NB_IADDR  current program counter.
- i_reg_data  in  NB_DATA  register-bank read data, 1-cycle latency.
- i_mem_data  in  NB_DATA  data-memory read data, 1-cycle latency.
- o_tx_byte  out  8  byte to UART transmitter.
- o_tx_start  out  1  one-cycle transmit request.
- o_enable_pipe  out  1  pipeline clock enable.
- o_imem_we  out  1  instruction-memory write strobe.
- o_imem_addr  out  NB_IADDR  instruction write address.
- o_imem_data  out  NB_DATA  assembled instruction.
- o_load_sel  out  1  high while loading; selects o_imem_addr at imem mux.
- o_reg_addr  out  clog2(N_REGS)  register read address.
- o_mem_addr  out  NB_MADDR  data-memory read address.
- o_state  out  4  encoded current state.

Function
REQ-003 States SHALL be IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SEND_PC, SEND_CYC, SEND_REG, SEND_MEM.
REQ-004 IDLE: byte 0x01 -> LD_CNT; 0x10 -> RUN; 0x20 -> STEP; any other byte SHALL be ignored.
REQ-005 LD_CNT: next byte SHALL be instruction count N; N=0 -> IDLE; N > 2^NB_IADDR SHALL be clamped to 2^NB_IADDR.
REQ-006 LD_BYTE: SHALL collect NB_DATA/8 bytes MSB-first into a shift register, then enter LD_WR.
REQ-007 LD_WR:
- SHALL pulse o_imem_we for exactly one cycle with o_imem_addr = word index, starting at 0.
- After the Nth word -> IDLE; otherwise -> LD_BYTE.
REQ-008 o_load_sel SHALL be high in LD_CNT, LD_BYTE and LD_WR only.
REQ-009 RUN:
- o_enable_pipe SHALL be high.
- 32-bit cycle counter SHALL increment each enabled cycle, saturating at 0xFFFFFFFF.
- On i_halt, o_enable_pipe SHALL drop the same cycle and the state -> SEND_PC.
REQ-010 STEP:
- Byte 0x30 SHALL give one o_enable_pipe pulse, count one cycle, then dump (SEND_PC...).
- After the dump -> STEP, unless i_halt was seen during the step, then -> IDLE.
- Byte 0x2F SHALL return to IDLE; other bytes SHALL be ignored.
REQ-011 Dump order SHALL be:
- PC, zero-extended to 32 bits.
- Cycle counter, 32 bits.
- N_REGS registers, ascending address.
- 2^NB_MADDR memory words, ascending address.
- All values MSB-first.
REQ-012 Per byte: o_tx_start SHALL pulse one cycle with o_tx_byte stable until i_tx_done; the next byte SHALL NOT start before i_tx_done.
REQ-013 Register/memory address SHALL be applied one cycle before sampling read data; a read word SHALL be captured before its first byte is sent.
REQ-014 i_rx_done during RUN or any SEND state SHALL be ignored.
REQ-015 i_halt in IDLE or the load states SHALL be ignored.
REQ-016 After a RUN dump completes -> IDLE; the cycle counter SHALL clear on entry to RUN or STEP from IDLE.
REQ-017 Simultaneous i_halt and i_rx_done in RUN: halt SHALL take priority.

Reset
REQ-018 i_reset low SHALL immediately force IDLE, all outputs 0, and cycle counter, word index and byte counters 0, including mid-load or mid-dump.
REQ-019 First edge after reset release SHALL evaluate IDLE; a partial load SHALL NOT be resumed.

Verification
REQ-020 Send 0x01, 0x02, 02 03 04 05, 06 07 08 09 -> two o_imem_we pulses: addr 0 data 0x02030405, addr 1 data 0x06070809; then IDLE.
REQ-021 Send 0x10, hold 4 cycles, i_halt with i_pc=3 -> bytes 00 00 00 03, cycle count 00 00 00 04, then 32 registers and 128 memory words, each gated by i_tx_done.
REQ-022 Send 0x20, 0x30 twice -> two single-cycle o_enable_pipe pulses; second dump carries cycle count 2.
REQ-023 Send 0x01, 0x00 -> no o_imem_we; return to IDLE; unknown byte 0x55 in IDLE -> no state change.
REQ-024 Assert i_reset low during SEND_REG -> outputs 0 and IDLE at once; a subsequent 0x10 run restarts the cycle count at 0.
REQ-025 Withhold i_tx_done for 50 cycles during dump -> o_tx_byte stable, no second o_tx_start.
